tmds_channel_encoder: RTL and testbench
=======================================

Name: tmds_channel_encoder

Overview:
- Full DVI 1.0 TMDS 8b/10b encoder for one channel, clocked at pixel rate.
- Drives the 10-bit symbol that the x5 DDR serializer latches once per pixel clock.
- Replaces the restricted 8-symbol scheme, so arbitrary 8-bit pixel values are sent DC-balanced.
- Three instances (blue, green, red) sit between the video timing/pattern logic and the serializer.

Parameters:
- CTRL_RESET, 2'b00: control code whose symbol is driven on symbol_out during and just after reset.

Ports:
- clk_pixel  input  1  pixel clock (25 MHz for 640x480).
- reset  input  1  asynchronous, active-high reset.
- data_in  input  8  pixel component, sampled when de_in=1.
- ctrl_in  input  2  {c1,c0}, sampled when de_in=0 (blue channel: {vsync,hsync}).
- de_in  input  1  data enable: 1 = active video, 0 = control period.
- symbol_out  output  10  TMDS symbol, bit 0 transmitted first.
- de_out  output  1  de_in delayed to align with symbol_out.
- disparity  output  5  signed running disparity (cnt), for debug and verification.

Behaviour:
- Reset is asynchronous. It immediately forces:
  - symbol_out = control symbol of CTRL_RESET (default 10'b1101010100);
  - de_out = 0, disparity = 0;
  - all stage registers cleared, with de = 0 and ctrl = CTRL_RESET.
- Reset asserted mid-stream discards in-flight symbols. The first input sampled after deassertion appears 2 cycles later.
- Latency is fixed at 2 clk_pixel cycles for both data and control. There is no handshake; one symbol is produced every cycle.
- Stage 1 (registered): N1D = number of ones in data_in.
  - If N1D>4, or N1D==4 with data_in[0]==0: q_m[0]=D[0], q_m[i]=~(q_m[i-1]^D[i]), q_m[8]=0.
  - Otherwise: q_m[i]=q_m[i-1]^D[i], q_m[8]=1.
  - Register q_m[8:0], N1 and N0 of q_m[7:0] (4 bits each), de_in and ctrl_in.
- Stage 2 (registered), when de=1 (cnt is 5-bit signed; arithmetic is sign-extended; the factor 2 is a left shift):
  - If cnt==0 or N1==N0:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
    - cnt += q_m[8] ? (N1-N0) : (N0-N1).
  - Else if (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
    - out = {1, q_m[8], ~q_m[7:0]};
    - cnt += 2*q_m[8] + (N0-N1).
  - Else:
    - out = {0, q_m[8], q_m[7:0]};
    - cnt += (N1-N0) - 2*(~q_m[8]).
- Stage 2, when de=0: cnt <= 0, and out is the control symbol:
  - 00 -> 1101010100
  - 01 -> 0010101011
  - 10 -> 0101010100
  - 11 -> 1010101011
- de transitions: each cycle is encoded according to its own sampled de. cnt is zeroed on every control cycle, so each active line starts at cnt=0.
- cnt must stay within -10..+10. An implementation exceeding this range is a bug; the bench asserts it.

Test Plan:
- Reset with CTRL_RESET=00 -> symbol_out=0x354, de_out=0, disparity=0. These hold while reset=1 regardless of inputs.
- de_in=0 with ctrl_in=00,01,10,11 on consecutive cycles -> 2 cycles later symbol_out=0x354, 0x0AB, 0x154, 0x2AB in order; disparity stays 0.
- de_in=1, data_in=0x00 for three cycles starting from cnt=0 -> symbols 0x100, 0x3FF, 0x100; disparity -8, +2, -6.
- de_in=1, data_in=0xFF from cnt=0 -> symbol 0x200, disparity -8. Then de_in=0 for one cycle -> disparity returns to 0.
- 10000 random data bytes with random de gaps:
  - decode each symbol against a golden model and require it to equal the input;
  - require |disparity|<=10 at all times;
  - require the cumulative ones-minus-zeros over each active run to match disparity.
- Assert reset mid-line while disparity!=0 -> outputs return to reset values within the same cycle. After release, the first symbol equals the CTRL_RESET control symbol until new inputs propagate 2 cycles later.

Source files
------------

// File: rtl/tmds_channel_encoder_if.sv
// Pixel-side bundle of one TMDS channel: video/control in, 10-bit symbol out.
// Unclocked, no handshake: a new symbol is taken and produced every pixel clock.
interface tmds_channel_encoder_if;
    logic [7:0] data_in;
    logic [1:0] ctrl_in;
    logic       de_in;
    logic [9:0] symbol_out;
    logic       de_out;
    logic [4:0] disparity;

    modport master (
        output data_in, ctrl_in, de_in,
        input  symbol_out, de_out, disparity
    );

    modport slave (
        input  data_in, ctrl_in, de_in,
        output symbol_out, de_out, disparity
    );
endinterface

// File: rtl/tmds_channel_encoder.sv
// DVI 1.0 TMDS 8b/10b encoder for one channel, DC-balanced via running disparity.
// Fixed 2-cycle latency for data and control; no backpressure, one symbol per clock.
module tmds_channel_encoder #(
    parameter logic [1:0] CTRL_RESET = 2'b00
) (
    input  logic                 clk_pixel,
    input  logic                 reset,
    tmds_channel_encoder_if.slave bus
);

    function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    localparam logic [9:0] RESET_SYMBOL = ctrl_symbol(CTRL_RESET);

    logic [8:0]        q_m_d, q_m_q;
    logic [3:0]        n1_d, n1_q, n0_d, n0_q;
    logic              de1_d, de1_q;
    logic [1:0]        ctrl1_d, ctrl1_q;
    logic [9:0]        sym_d, sym_q;
    logic              de2_d, de2_q;
    logic signed [4:0] cnt_d, cnt_q;

    // XNOR chain equals the XOR prefix with every odd bit flipped, avoiding a ripple
    always_comb begin
        logic [3:0] n1d;
        logic       parity;
        logic [7:0] prefix;
        logic       use_xnor;
        n1d    = '0;
        parity = 1'b0;
        prefix = '0;
        for (int i = 0; i < 8; i++) begin
            n1d       = n1d + {3'b000, bus.data_in[i]};
            parity    = parity ^ bus.data_in[i];
            prefix[i] = parity;
        end
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !bus.data_in[0]);
        q_m_d    = {~use_xnor, prefix ^ (use_xnor ? 8'hAA : 8'h00)};
        n1_d     = '0;
        for (int i = 0; i < 8; i++) begin
            n1_d = n1_d + {3'b000, q_m_d[i]};
        end
        n0_d    = 4'd8 - n1_d;
        de1_d   = bus.de_in;
        ctrl1_d = bus.ctrl_in;
    end

    always_comb begin
        logic signed [4:0] diff;
        logic signed [4:0] two_q8;
        logic signed [4:0] two_nq8;
        logic              cnt_pos;
        logic              cnt_neg;
        diff    = $signed({1'b0, n1_q}) - $signed({1'b0, n0_q});
        two_q8  = $signed({3'b000, q_m_q[8], 1'b0});
        two_nq8 = $signed({3'b000, ~q_m_q[8], 1'b0});
        cnt_pos = (cnt_q != 5'sd0) && !cnt_q[4];
        cnt_neg = cnt_q[4];
        sym_d   = ctrl_symbol(ctrl1_q);
        cnt_d   = '0;
        de2_d   = de1_q;
        if (de1_q) begin
            if ((cnt_q == 5'sd0) || (n1_q == n0_q)) begin
                sym_d = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
                cnt_d = q_m_q[8] ? (cnt_q + diff) : (cnt_q - diff);
            end else if ((cnt_pos && (n1_q > n0_q)) || (cnt_neg && (n0_q > n1_q))) begin
                sym_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
                cnt_d = cnt_q + two_q8 - diff;
            end else begin
                sym_d = {1'b0, q_m_q[8], q_m_q[7:0]};
                cnt_d = cnt_q + diff - two_nq8;
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            q_m_q   <= '0;
            n1_q    <= '0;
            n0_q    <= '0;
            de1_q   <= 1'b0;
            ctrl1_q <= CTRL_RESET;
            sym_q   <= RESET_SYMBOL;
            de2_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            q_m_q   <= q_m_d;
            n1_q    <= n1_d;
            n0_q    <= n0_d;
            de1_q   <= de1_d;
            ctrl1_q <= ctrl1_d;
            sym_q   <= sym_d;
            de2_q   <= de2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.symbol_out = sym_q;
    assign bus.de_out     = de2_q;
    assign bus.disparity  = cnt_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for tmds_channel_encoder: stimulus pushes expected symbols tagged
// with their due cycle; a negedge monitor pops, compares, decodes and tracks balance.
`timescale 1ns/1ps
module tb_tmds_channel_encoder;

    logic clk_pixel = 1'b0;
    logic reset     = 1'b1;
    always #20 clk_pixel = ~clk_pixel;

    tmds_channel_encoder_if vif();

    tmds_channel_encoder #(.CTRL_RESET(2'b00)) dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .bus       (vif)
    );

    typedef struct {
        int         due;
        logic [9:0] sym;
        logic       de;
        int         disp;
        logic [7:0] data;
    } exp_t;

    exp_t       q[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         m_cnt    = 0;
    int         acc      = 0;
    logic [9:0] ctrl_sym [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    always @(posedge clk_pixel) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ones_minus_zeros(input logic [9:0] s);
        return 2 * $countones(s) - 10;
    endfunction

    // Reference encoder: picks inversion from the rules, then advances the running
    // count by the actual ones-minus-zeros of the chosen symbol.
    function automatic logic [9:0] model_enc(input logic de, input logic [7:0] d,
                                             input logic [1:0] c);
        logic [8:0] qm;
        logic [9:0] s;
        logic       xn, inv;
        int         n1, n0, n1d;
        if (!de) begin
            m_cnt = 0;
            return ctrl_sym[c];
        end
        n1d   = $countones(d);
        xn    = (n1d > 4) || (n1d == 4 && !d[0]);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (m_cnt == 0 || n1 == n0)                               inv = !qm[8];
        else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) inv = 1'b1;
        else                                                       inv = 1'b0;
        s = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
        m_cnt += ones_minus_zeros(s);
        return s;
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] s);
        logic [7:0] qm, d;
        qm   = s[9] ? ~s[7:0] : s[7:0];
        d[0] = qm[0];
        for (int i = 1; i < 8; i++)
            d[i] = s[8] ? (qm[i] ^ qm[i-1]) : ~(qm[i] ^ qm[i-1]);
        return d;
    endfunction

    task automatic push(input logic de, input logic [7:0] d, input logic [1:0] c, input int due);
        exp_t e;
        e.due  = due;
        e.de   = de;
        e.data = d;
        e.sym  = model_enc(de, d, c);
        e.disp = m_cnt;
        q.push_back(e);
    endtask

    task automatic drive(input logic de, input logic [7:0] d, input logic [1:0] c);
        @(posedge clk_pixel);
        #1;
        vif.de_in   = de;
        vif.data_in = d;
        vif.ctrl_in = c;
        push(de, d, c, cyc + 2);
    endtask

    task automatic drive_k(input logic de, input logic [7:0] d, input logic [1:0] c,
                           input logic [9:0] ksym, input int kdisp);
        drive(de, d, c);
        q[q.size()-1].sym  = ksym;
        q[q.size()-1].disp = kdisp;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_symbol"},    int'(vif.symbol_out), 'h354);
        check({tag, "_de_out"},    int'(vif.de_out), 0);
        check({tag, "_disparity"}, int'($signed(vif.disparity)), 0);
    endtask

    always @(negedge clk_pixel) begin : monitor
        exp_t e;
        int   dv;
        if (reset) begin
            acc = 0;
        end else begin
            dv = int'($signed(vif.disparity));
            check("disparity_in_range", (dv >= -10 && dv <= 10) ? 1 : 0, 1);
            while (q.size() > 0 && q[0].due < cyc) begin
                check("output_due_cycle", cyc, q[0].due);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                check("symbol", int'(vif.symbol_out), int'(e.sym));
                check("de_out", int'(vif.de_out), int'(e.de));
                check("disparity", dv, e.disp);
                if (e.de) begin
                    check("decode", int'(tmds_decode(vif.symbol_out)), int'(e.data));
                    acc += ones_minus_zeros(vif.symbol_out);
                    check("run_balance", acc, dv);
                end else begin
                    acc = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #8000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, run, gap;
        logic       fixed_mode;
        logic [7:0] fixed_byte, b;
        vif.de_in   = 1'b0;
        vif.data_in = 8'h00;
        vif.ctrl_in = 2'b00;

        // outputs must hold reset values whatever the inputs do
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_pixel);
            vif.de_in   = 1'($urandom);
            vif.data_in = 8'($urandom);
            vif.ctrl_in = 2'($urandom);
            #1;
            check_reset_outputs("reset_hold");
        end
        @(negedge clk_pixel);
        vif.de_in   = 1'b0;
        vif.ctrl_in = 2'b00;
        reset       = 1'b0;
        m_cnt       = 0;

        drive_k(1'b0, 8'($urandom), 2'b00, 10'h354, 0);
        drive_k(1'b0, 8'($urandom), 2'b01, 10'h0AB, 0);
        drive_k(1'b0, 8'($urandom), 2'b10, 10'h154, 0);
        drive_k(1'b0, 8'($urandom), 2'b11, 10'h2AB, 0);
        drive_k(1'b1, 8'h00, 2'($urandom), 10'h100, -8);
        drive_k(1'b1, 8'h00, 2'($urandom), 10'h3FF,  2);
        drive_k(1'b1, 8'h00, 2'($urandom), 10'h100, -6);
        drive_k(1'b0, 8'($urandom), 2'b00, 10'h354, 0);
        drive_k(1'b1, 8'hFF, 2'($urandom), 10'h200, -8);
        drive_k(1'b0, 8'($urandom), 2'b01, 10'h0AB, 0);

        n = 0;
        while (n < 10000) begin
            run        = $urandom_range(1, 40);
            fixed_mode = ($urandom_range(0, 3) == 0);
            fixed_byte = 8'($urandom);
            for (int j = 0; j < run && n < 10000; j++) begin
                b = fixed_mode ? fixed_byte : 8'($urandom);
                drive(1'b1, b, 2'($urandom));
                n++;
            end
            gap = $urandom_range(1, 3);
            for (int j = 0; j < gap; j++)
                drive(1'b0, 8'($urandom), 2'($urandom));
        end

        // mid-line reset while the running count is non-zero
        drive(1'b0, 8'h00, 2'b00);
        drive(1'b1, 8'h00, 2'b00);
        repeat (3) @(negedge clk_pixel);
        check("pre_reset_disparity_nonzero", (vif.disparity != 5'd0) ? 1 : 0, 1);
        #5;
        reset = 1'b1;
        q.delete();
        vif.de_in   = 1'b1;
        vif.data_in = 8'hAA;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk_pixel);
        check_reset_outputs("reset_held_over_edge");
        @(negedge clk_pixel);
        reset = 1'b0;
        m_cnt = 0;
        push(1'b1, 8'hAA, 2'b00, cyc + 2);
        #1;
        check_reset_outputs("release");
        drive(1'b1, 8'h55, 2'b00);
        @(negedge clk_pixel);
        #1;
        check_reset_outputs("first_after_release");
        for (int i = 0; i < 6; i++)
            drive(1'($urandom), 8'($urandom), 2'($urandom));

        for (int k = 0; k < 10 && q.size() > 0; k++) begin
            @(negedge clk_pixel);
            #1;
        end
        check("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
